// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants: forwarding-mux select codes, x0 address and the
// destination-tracker entry carried through EX/MEM/WB.
package riscv_pipe_pkg;

  localparam int RV_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RSVD  = 2'b11;

  localparam logic [RV_REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                     v;
    logic [RV_REG_ADDR_W-1:0] rd;
    logic                     rw;
    logic                     mr;
  } trk_entry_t;

  // An entry only produces a forwardable value if it is live, writes, and is not x0.
  function automatic logic is_writer(trk_entry_t e);
    return e.v & e.rw & (e.rd != REG_X0);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-stage select bundle between the pipeline (master)
// and the forwarding/hazard unit (slave).
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/hazard_dst_track.sv
// Three-entry EX/MEM/WB destination shift register; a bubble replaces the
// ID instruction on its way into EX.
module hazard_dst_track
  import riscv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bubble,
  input  trk_entry_t i_id,
  output trk_entry_t o_ex,
  output trk_entry_t o_mem,
  output trk_entry_t o_wb
);

  localparam trk_entry_t BUBBLE = '0;

  trk_entry_t r_stage [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage[0] <= BUBBLE;
      r_stage[1] <= BUBBLE;
      r_stage[2] <= BUBBLE;
    end else begin
      r_stage[0] <= i_bubble ? BUBBLE : i_id;
      r_stage[1] <= r_stage[0];
      r_stage[2] <= r_stage[1];
    end
  end

  assign o_ex  = r_stage[0];
  assign o_mem = r_stage[1];
  assign o_wb  = r_stage[2];

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and load-use stall for the 5-stage RV32 pipeline.
// Optional stall performance counter: define HAZARD_PERF_CNT_EN.
module fwd_hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = RV_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  trk_entry_t            w_id;
  trk_entry_t            w_ex;
  trk_entry_t            w_mem;
  trk_entry_t            w_wb;
  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_hit_ex;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [1:0]            r_fwd_a_sel;
  logic [1:0]            r_fwd_b_sel;
  logic                  w_unused_wb;

  assign w_rs1 = bus.id_rs1;
  assign w_rs2 = bus.id_rs2;

  assign w_id.v  = bus.id_valid;
  assign w_id.rd = bus.id_rd;
  assign w_id.rw = bus.id_regwrite;
  assign w_id.mr = bus.id_memread;

  hazard_dst_track u_track (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (w_bubble),
    .i_id     (w_id),
    .o_ex     (w_ex),
    .o_mem    (w_mem),
    .o_wb     (w_wb)
  );

  // WB producers reach ID through the register file, so only ex/mem are compared.
  assign w_unused_wb = ^{w_wb, w_mem.mr};

  function automatic logic [1:0] fwd_sel(logic use_rs, logic [REG_ADDR_W-1:0] rs,
                                         trk_entry_t ex, trk_entry_t mem);
    if (!use_rs)                         return FWD_RF;
    if (is_writer(ex)  && rs == ex.rd)   return FWD_EXMEM;
    if (is_writer(mem) && rs == mem.rd)  return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign w_hit_ex = (bus.id_use_rs1 && w_rs1 == w_ex.rd) ||
                    (bus.id_use_rs2 && w_rs2 == w_ex.rd);

  // A flush kills the consumer, so it overrides any load-use condition.
  assign w_stall  = bus.id_valid && !bus.ex_flush && is_writer(w_ex) && w_ex.mr && w_hit_ex;
  assign w_bubble = w_stall || bus.ex_flush || !bus.id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
    end else begin
      r_fwd_a_sel <= w_bubble ? FWD_RF : fwd_sel(bus.id_use_rs1, w_rs1, w_ex, w_mem);
      r_fwd_b_sel <= w_bubble ? FWD_RF : fwd_sel(bus.id_use_rs2, w_rs2, w_ex, w_mem);
    end
  end

  assign bus.fwd_a_sel = r_fwd_a_sel;
  assign bus.fwd_b_sel = r_fwd_b_sel;
  assign bus.stall     = w_stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a queue of issued instructions models the
// pipeline and predicts stall/selects each cycle, plus literal spot checks.
module tb_fwd_hazard_unit;
  import riscv_pipe_pkg::*;

  localparam int AW = 5;
  localparam int CW = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();
  fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  rec_t        hist[$];
  logic [1:0]  exp_a, exp_b;
  longint      exp_cnt;
  logic        last_stall;
  logic [CW-1:0] cnt0;
  int          cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit writer(rec_t r);
    return r.v && r.rw && (r.rd != 0);
  endfunction

  function automatic logic [1:0] model_sel(bit use_rs, int rs, rec_t ex, rec_t mem);
    if (!use_rs) return 2'b00;
    if (writer(ex) && rs == ex.rd) return 2'b01;
    if (writer(mem) && rs == mem.rd) return 2'b10;
    return 2'b00;
  endfunction

  task automatic reset_model();
    rec_t b;
    b = '{v: 0, rd: 0, rw: 0, mr: 0};
    hist = {b, b, b};
    exp_a = 2'b00;
    exp_b = 2'b00;
    exp_cnt = 0;
  endtask

  // Called at posedge+1; drives one ID instruction, checks at negedge, steps model at posedge.
  task automatic cycle(input string tag, input bit v, input int rs1, input int rs2,
                       input bit u1, input bit u2, input int rd, input bit rw,
                       input bit mr, input bit fl);
    rec_t ex, mem, nr;
    bit   e_stall, bub;
    logic [AW-1:0] a1, a2, ad;
    a1 = rs1[AW-1:0];
    a2 = rs2[AW-1:0];
    ad = rd[AW-1:0];
    bus.id_valid = v;  bus.id_rs1 = a1;  bus.id_rs2 = a2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.id_rd = ad; bus.id_regwrite = rw; bus.id_memread = mr; bus.ex_flush = fl;
    @(negedge clk);
    ex  = hist[0];
    mem = hist[1];
    e_stall = v && !fl && writer(ex) && ex.mr &&
              ((u1 && rs1 == ex.rd) || (u2 && rs2 == ex.rd));
    last_stall = bus.stall;
    check({tag, " stall"}, {63'd0, bus.stall}, {63'd0, e_stall});
    check({tag, " fwd_a_sel"}, {62'd0, bus.fwd_a_sel}, {62'd0, exp_a});
    check({tag, " fwd_b_sel"}, {62'd0, bus.fwd_b_sel}, {62'd0, exp_b});
    check({tag, " stall_count"}, {32'd0, bus.stall_count}, exp_cnt);
    $display("cyc %0d %s v=%0b rs1=%0d rs2=%0d rd=%0d rw=%0b mr=%0b fl=%0b | stall=%0b a=%0b b=%0b cnt=%0d",
             cyc, tag, v, rs1, rs2, rd, rw, mr, fl, bus.stall, bus.fwd_a_sel, bus.fwd_b_sel,
             bus.stall_count);
    @(posedge clk);
    cyc++;
    if (CNT_EN && e_stall && exp_cnt < ((64'd1 << CW) - 1)) exp_cnt++;
    bub   = e_stall || fl || !v;
    exp_a = bub ? 2'b00 : model_sel(u1, rs1, ex, mem);
    exp_b = bub ? 2'b00 : model_sel(u2, rs2, ex, mem);
    nr = '{v: !bub, rd: rd, rw: !bub && rw, mr: !bub && mr};
    hist.push_front(nr);
    void'(hist.pop_back());
    #1;
  endtask

  initial begin
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0;
    bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.ex_flush = 0;
    reset_model();
    #1 rst_n = 1'b0;
    #2;
    check("reset stall", {63'd0, bus.stall}, 64'd0);
    check("reset fwd_a_sel", {62'd0, bus.fwd_a_sel}, 64'd0);
    check("reset fwd_b_sel", {62'd0, bus.fwd_b_sel}, 64'd0);
    check("reset stall_count", {32'd0, bus.stall_count}, 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // EX->EX forward
    cycle("t1 add x5",      1, 1, 2, 1, 1, 5, 1, 0, 0);
    cycle("t1 add x6,x5,x1", 1, 5, 1, 1, 1, 6, 1, 0, 0);
    check("t1 lit a", {62'd0, bus.fwd_a_sel}, 64'd1);
    check("t1 lit b", {62'd0, bus.fwd_b_sel}, 64'd0);
    check("t1 lit stall", {63'd0, last_stall}, 64'd0);

    // MEM->EX forward across a nop
    cycle("t2 add x5",       1, 3, 4, 1, 1, 5, 1, 0, 0);
    cycle("t2 nop",          0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("t2 sub x7,x2,x5", 1, 2, 5, 1, 1, 7, 1, 0, 0);
    check("t2 lit b", {62'd0, bus.fwd_b_sel}, 64'd2);
    check("t2 lit a", {62'd0, bus.fwd_a_sel}, 64'd0);

    // newest producer wins
    cycle("t3 add x5 #1",  1, 8, 9, 1, 1, 5, 1, 0, 0);
    cycle("t3 add x5 #2",  1, 9, 8, 1, 1, 5, 1, 0, 0);
    cycle("t3 use x5,x5",  1, 5, 5, 1, 1, 10, 1, 0, 0);
    check("t3 lit a", {62'd0, bus.fwd_a_sel}, 64'd1);
    check("t3 lit b", {62'd0, bus.fwd_b_sel}, 64'd1);

    // load-use: one stall, then MEM/WB forward
    cnt0 = bus.stall_count;
    cycle("t4 lw x5",        1, 1, 0, 1, 0, 5, 1, 1, 0);
    cycle("t4 add x6 (stl)", 1, 5, 5, 1, 1, 6, 1, 0, 0);
    check("t4 lit stall on", {63'd0, last_stall}, 64'd1);
    cycle("t4 add x6 (go)",  1, 5, 5, 1, 1, 6, 1, 0, 0);
    check("t4 lit stall off", {63'd0, last_stall}, 64'd0);
    check("t4 lit a", {62'd0, bus.fwd_a_sel}, 64'd2);
    check("t4 lit b", {62'd0, bus.fwd_b_sel}, 64'd2);
    check("t4 lit count delta", {32'd0, bus.stall_count - cnt0}, {63'd0, CNT_EN});

    // x0 never forwarded, never stalls
    cycle("t5 add x0",     1, 1, 2, 1, 1, 0, 1, 0, 0);
    cycle("t5 read x0",    1, 0, 0, 1, 1, 11, 1, 0, 0);
    check("t5 lit a", {62'd0, bus.fwd_a_sel}, 64'd0);
    check("t5 lit b", {62'd0, bus.fwd_b_sel}, 64'd0);
    cycle("t5 lw x0",      1, 1, 0, 1, 0, 0, 1, 1, 0);
    cycle("t5 read x0 #2", 1, 0, 0, 1, 1, 12, 1, 0, 0);
    check("t5 lit stall", {63'd0, last_stall}, 64'd0);

    // flush beats load-use
    cycle("t6 lw x5",        1, 1, 0, 1, 0, 5, 1, 1, 0);
    cycle("t6 add x6 flush", 1, 5, 5, 1, 1, 6, 1, 0, 1);
    check("t6 lit stall", {63'd0, last_stall}, 64'd0);
    check("t6 lit a", {62'd0, bus.fwd_a_sel}, 64'd0);
    check("t6 lit b", {62'd0, bus.fwd_b_sel}, 64'd0);
    cycle("t6 nop",          0, 0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a stall
    cycle("t7 add x9",     1, 1, 2, 1, 1, 9, 1, 0, 0);
    cycle("t7 lw x5,(x9)", 1, 9, 0, 1, 0, 5, 1, 1, 0);
    check("t7 lit a", {62'd0, bus.fwd_a_sel}, 64'd1);
    bus.id_valid = 1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1; bus.id_use_rs2 = 0;
    bus.id_rd = 5'd6; bus.id_regwrite = 1; bus.id_memread = 0; bus.ex_flush = 0;
    #2;
    check("t7 stall before reset", {63'd0, bus.stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7 reset stall", {63'd0, bus.stall}, 64'd0);
    check("t7 reset fwd_a_sel", {62'd0, bus.fwd_a_sel}, 64'd0);
    check("t7 reset fwd_b_sel", {62'd0, bus.fwd_b_sel}, 64'd0);
    check("t7 reset stall_count", {32'd0, bus.stall_count}, 64'd0);
    bus.id_valid = 0;
    #2 rst_n = 1'b1;
    reset_model();
    @(posedge clk);
    #1;

    // mixed traffic on a small register window
    for (int i = 0; i < 60; i++) begin
      cycle("mix", $urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
